// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment table and width helper.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns, entry n = glyph for hex digit n
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side bus of the scan driver: digit data in, board pin drive out.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  import seg7_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   Anode;
  logic [7:0]              Cathode;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    load_pending;

  modport master (
    output value, dp_en, blank, lz_en, load,
    input  Anode, Cathode, digit_idx, frame_done, load_pending
  );

  modport slave (
    input  value, dp_en, blank, lz_en, load,
    output Anode, Cathode, digit_idx, frame_done, load_pending
  );

endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low segment pattern, with decimal point and forced blanking.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) seg_o = SEG_TABLE[nibble_i] & {~dp_i, 7'h7F};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: shadow registers, scan divider,
// leading-zero suppression, anti-ghost guard and registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned GUARD      = 16,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned SYNC_LOAD  = 1
) (
  input  logic              clock,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned ND    = NUM_DIGITS;
  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
  localparam int unsigned DIV_W = idx_width(CLK_DIV);
  localparam logic [ND-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? {ND{1'b1}} : {ND{1'b0}};
  localparam logic [7:0]    CATH_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  digit_idx_q, digit_idx_d;
  logic [4*ND-1:0]   val_q, val_d, pend_val_q, pend_val_d;
  logic [ND-1:0]     dp_q, dp_d, pend_dp_q, pend_dp_d;
  logic [ND-1:0]     blank_q, blank_d, pend_blank_q, pend_blank_d;
  logic              load_pending_q, load_pending_d;
  logic              frame_done_q, frame_done_d;
  logic [ND-1:0]     anode_q, anode_d;
  logic [7:0]        cathode_q, cathode_d;

  logic              slot_end_c, frame_end_c, in_guard_c, lz_blank_c;
  logic [ND-1:0]     hi_zero_c;
  logic [7:0]        seg_c;

  // Scan position: divider within a slot, digit index across slots
  always_comb begin
    slot_end_c  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    frame_end_c = slot_end_c && (digit_idx_q == IDX_W'(ND - 1));
    div_cnt_d   = slot_end_c ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_end_c) digit_idx_d = frame_end_c ? '0 : digit_idx_q + IDX_W'(1);
    // Registered pulse aligned with the last cycle of the last slot
    frame_done_d = (div_cnt_d == DIV_W'(CLK_DIV - 1)) && (digit_idx_d == IDX_W'(ND - 1));
  end

  // Shadow / pending load path; loads landing on the frame edge bypass pending
  always_comb begin
    val_d          = val_q;
    dp_d           = dp_q;
    blank_d        = blank_q;
    pend_val_d     = pend_val_q;
    pend_dp_d      = pend_dp_q;
    pend_blank_d   = pend_blank_q;
    load_pending_d = load_pending_q;
    if (SYNC_LOAD == 0) begin
      if (bus.load) begin
        val_d   = bus.value;
        dp_d    = bus.dp_en;
        blank_d = bus.blank;
      end
    end else if (frame_end_c) begin
      if (bus.load) begin
        val_d   = bus.value;
        dp_d    = bus.dp_en;
        blank_d = bus.blank;
      end else if (load_pending_q) begin
        val_d   = pend_val_q;
        dp_d    = pend_dp_q;
        blank_d = pend_blank_q;
      end
      load_pending_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d     = bus.value;
      pend_dp_d      = bus.dp_en;
      pend_blank_d   = bus.blank;
      load_pending_d = 1'b1;
    end
  end

  // hi_zero_c[i]: every shadow nibble at index >= i is zero
  always_comb begin
    logic acc;
    acc       = 1'b1;
    hi_zero_c = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      acc          = acc && (val_q[i*4 +: 4] == 4'h0);
      hi_zero_c[i] = acc;
    end
  end

  assign lz_blank_c = bus.lz_en && (digit_idx_q != '0) && hi_zero_c[digit_idx_q];
  assign in_guard_c = (32'(div_cnt_q) < GUARD);

  seg7_decode u_decode (
    .nibble_i (val_q[{digit_idx_q, 2'b00} +: 4]),
    .dp_i     (dp_q[digit_idx_q]),
    .blank_i  (blank_q[digit_idx_q] || lz_blank_c),
    .seg_o    (seg_c)
  );

  always_comb begin
    anode_d   = ANODE_OFF;
    cathode_d = CATH_OFF;
    if (!in_guard_c) begin
      anode_d   = ANODE_OFF ^ (ND'(1) << digit_idx_q);
      cathode_d = (ACTIVE_LOW != 0) ? seg_c : ~seg_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q      <= '0;
      digit_idx_q    <= '0;
      val_q          <= '0;
      dp_q           <= '0;
      blank_q        <= '0;
      pend_val_q     <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      load_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      anode_q        <= ANODE_OFF;
      cathode_q      <= CATH_OFF;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_idx_q    <= digit_idx_d;
      val_q          <= val_d;
      dp_q           <= dp_d;
      blank_q        <= blank_d;
      pend_val_q     <= pend_val_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      load_pending_q <= load_pending_d;
      frame_done_q   <= frame_done_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
    end
  end

  assign bus.Anode        = anode_q;
  assign bus.Cathode      = cathode_q;
  assign bus.digit_idx    = digit_idx_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.load_pending = load_pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: immediate-load and frame-synchronous instances side by side,
// compared every cycle against a slot-arithmetic model of the display.
module tb_seg7_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned CD    = 4;
  localparam int unsigned GD    = 1;
  localparam int unsigned FRAME = N * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_en, blank;
  logic        lz_en, load;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus1 ();

  assign bus0.value = value;
  assign bus0.dp_en = dp_en;
  assign bus0.blank = blank;
  assign bus0.lz_en = lz_en;
  assign bus0.load  = load;
  assign bus1.value = value;
  assign bus1.dp_en = dp_en;
  assign bus1.blank = blank;
  assign bus1.lz_en = lz_en;
  assign bus1.load  = load;

  seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(1), .SYNC_LOAD(0))
    dut0 (.clock(clk), .reset(rst), .bus(bus0));
  seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(1), .SYNC_LOAD(1))
    dut1 (.clock(clk), .reset(rst), .bus(bus1));

  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: t = cycles since reset release; index 0 = immediate load, 1 = frame-synchronous
  int unsigned t;
  logic [15:0] m_val [2];
  logic [3:0]  m_dp  [2];
  logic [3:0]  m_bl  [2];
  logic [15:0] p_val;
  logic [3:0]  p_dp, p_bl;
  logic        m_lp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode(input int unsigned tc);
    int unsigned idx;
    idx = (tc / CD) % N;
    if ((tc % CD) < GD) return 4'hF;
    return 4'hF ^ 4'(1 << idx);
  endfunction

  function automatic logic [7:0] exp_cathode(input int unsigned tc, input logic [15:0] v,
                                             input logic [3:0] dp, input logic [3:0] bl,
                                             input logic lz);
    int unsigned idx;
    logic [7:0]  s;
    idx = (tc / CD) % N;
    if ((tc % CD) < GD) return 8'hFF;
    if (bl[idx]) return 8'hFF;
    if (lz && idx > 0 && (v >> (4 * idx)) == 16'h0) return 8'hFF;
    s = seg_ref[4'((v >> (4 * idx)) & 16'hF)];
    if (dp[idx]) s = s & 8'h7F;
    return s;
  endfunction

  task automatic model_clear();
    t = 0;
    for (int k = 0; k < 2; k++) begin
      m_val[k] = '0;
      m_dp[k]  = '0;
      m_bl[k]  = '0;
    end
    p_val = '0;
    p_dp  = '0;
    p_bl  = '0;
    m_lp  = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_anode0",  32'(bus0.Anode),        32'hF);
    check("rst_cath0",   32'(bus0.Cathode),      32'hFF);
    check("rst_idx0",    32'(bus0.digit_idx),    32'h0);
    check("rst_fd0",     32'(bus0.frame_done),   32'h0);
    check("rst_anode1",  32'(bus1.Anode),        32'hF);
    check("rst_cath1",   32'(bus1.Cathode),      32'hFF);
    check("rst_idx1",    32'(bus1.digit_idx),    32'h0);
    check("rst_lp1",     32'(bus1.load_pending), 32'h0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock edge: predict from the pre-edge cycle, apply load rules, then compare
  task automatic step();
    logic [7:0] ec [2];
    logic [3:0] ea;
    logic       efd;
    int unsigned ei;
    @(posedge clk);
    ea = exp_anode(t);
    for (int k = 0; k < 2; k++) ec[k] = exp_cathode(t, m_val[k], m_dp[k], m_bl[k], lz_en);
    efd = ((t + 1) % FRAME) == FRAME - 1;
    ei  = ((t + 1) / CD) % N;
    if (load) begin
      m_val[0] = value;
      m_dp[0]  = dp_en;
      m_bl[0]  = blank;
    end
    if ((t % FRAME) == FRAME - 1) begin
      if (load) begin
        m_val[1] = value;
        m_dp[1]  = dp_en;
        m_bl[1]  = blank;
      end else if (m_lp) begin
        m_val[1] = p_val;
        m_dp[1]  = p_dp;
        m_bl[1]  = p_bl;
      end
      m_lp = 1'b0;
    end else if (load) begin
      p_val = value;
      p_dp  = dp_en;
      p_bl  = blank;
      m_lp  = 1'b1;
    end
    t++;
    #1;
    check("anode0",   32'(bus0.Anode),        32'(ea));
    check("cathode0", 32'(bus0.Cathode),      32'(ec[0]));
    check("idx0",     32'(bus0.digit_idx),    32'(ei));
    check("fdone0",   32'(bus0.frame_done),   32'(efd));
    check("lpend0",   32'(bus0.load_pending), 32'h0);
    check("anode1",   32'(bus1.Anode),        32'(ea));
    check("cathode1", 32'(bus1.Cathode),      32'(ec[1]));
    check("idx1",     32'(bus1.digit_idx),    32'(ei));
    check("fdone1",   32'(bus1.frame_done),   32'(efd));
    check("lpend1",   32'(bus1.load_pending), 32'(m_lp));
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    value = '0;
    dp_en = '0;
    blank = '0;
    lz_en = 1'b0;
    load  = 1'b0;
    do_reset();

    value = 16'h1234;
    pulse_load();
    repeat (40) step();

    lz_en = 1'b1;
    value = 16'h0050;
    pulse_load();
    repeat (36) step();
    value = 16'h0000;
    pulse_load();
    repeat (36) step();

    lz_en = 1'b0;
    dp_en = 4'b0100;
    blank = 4'b0001;
    value = 16'hABCD;
    pulse_load();
    repeat (36) step();

    // Two loads inside one frame: the second must win at the wrap
    dp_en = '0;
    blank = '0;
    while ((t % FRAME) != 4) step();
    value = 16'h1111;
    pulse_load();
    repeat (3) step();
    value = 16'h2222;
    pulse_load();
    repeat (40) step();

    // Load on the frame_done cycle itself
    while ((t % FRAME) != FRAME - 1) step();
    value = 16'h5678;
    pulse_load();
    repeat (20) step();

    // Asynchronous reset in the middle of the digit 2 slot
    while (((t / CD) % N) != 2 || (t % CD) != 1) step();
    do_reset();
    repeat (20) step();

    repeat (800) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_en = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.
- Holds a shadow copy of all digit values and scans digits at a programmable refresh rate.
- Per digit, decodes hex to segments with decimal point, blanking, leading-zero suppression and an anti-ghosting guard interval.
- Sits between datapath registers and board Anode/Cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
CLK_DIV, 100000, clock cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at slot start with all anodes off (anti-ghost; 0 disables)
ACTIVE_LOW, 1, 1: Anode/Cathode low = on; 0: both inverted
SYNC_LOAD, 1, 1: load applied at frame wrap (tear-free); 0: applied next cycle

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
value  in  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0]
dp_en  in  NUM_DIGITS  decimal point on per digit
blank  in  NUM_DIGITS  force digit dark
lz_en  in  1  leading-zero suppression enable
load  in  1  strobe: capture value/dp_en/blank
Anode  out  NUM_DIGITS  digit enables, one-hot active per ACTIVE_LOW
Cathode  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
digit_idx  out  $clog2(NUM_DIGITS)  digit currently driven
frame_done  out  1  one-cycle pulse at the end of the last digit slot
load_pending  out  1  SYNC_LOAD=1 only: load captured, not yet applied

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset). The polarity and synchronicity are fixed.
- Reset values:
  - div_cnt=0, digit_idx=0.
  - Shadow value/dp/blank = 0.
  - Pending registers cleared; load_pending=0; frame_done=0.
  - Anode all off; Cathode all off (all 1s when ACTIVE_LOW=1).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. At div_cnt==CLK_DIV-1, digit_idx advances by 1 and wraps NUM_DIGITS-1 -> 0.
- frame_done: asserted the cycle div_cnt==CLK_DIV-1 and digit_idx==NUM_DIGITS-1.
- Load path:
  - SYNC_LOAD=0: load writes the shadow at the clock edge; outputs reflect it one cycle later.
  - SYNC_LOAD=1: load writes pending regs and sets load_pending. On the frame_done cycle, pending is copied to the shadow and load_pending clears.
  - A second load while pending overwrites pending (last wins).
  - load coincident with frame_done: the new data goes directly to the shadow; load_pending stays 0.
- Guard interval: while div_cnt < GUARD, Anode is all off and Cathode is all off.
- Otherwise:
  - Anode enables only bit digit_idx.
  - Cathode = decode(shadow nibble[digit_idx]) with dp = dp_en[digit_idx].
- Blank conditions: Cathode all off (dp included) if either of the following holds:
  - blank[digit_idx] is set.
  - lz_en=1, digit_idx>0, and every nibble at indices >= digit_idx is zero. Digit 0 is never LZ-blanked.
- Output timing: Anode/Cathode are registered. They follow div_cnt/digit_idx state with 1-cycle latency, so the outputs of a slot lag the slot by one cycle. digit_idx is the registered current index.
- Decode, active-low values, a–g plus dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=98, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp on clears bit7.
  - ACTIVE_LOW=0 bitwise-inverts Cathode and Anode.
- Reset mid-scan: all state returns to reset values immediately (async). Scan restarts from digit 0 after deassertion; pending load is lost.

Decomposition:
- Package seg7_pkg: 16-entry segment constant table (active-low), SEG_OFF=8'hFF, and a function for index width.
- Sub-module seg7_decode: combinational nibble+dp+blank -> 8-bit active-low segments. Instantiated once, polarity applied in the parent.
- Parent holds the divider, index counter, shadow/pending registers, LZ logic and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, GUARD=1.
- Reset, then value=16'h1234, load, SYNC_LOAD=0 -> slots show Anode 1110/1101/1011/0111 with Cathode 99/B0/A4/F9. First cycle of each slot: Anode 1111, Cathode FF. frame_done pulses every 16 cycles.
- lz_en=1, value=16'h0050, load -> digits 3,2 fully off; digit1=92; digit0=C0. value=16'h0000 -> only digit0 shows C0.
- dp_en=4'b0100, blank=4'b0001, value=16'hABCD -> digit2 Cathode=83&7F=03; digit0 Cathode=FF; digit1=C6; digit3=88.
- SYNC_LOAD=1: load 16'h1111 mid-frame, then 16'h2222 before wrap -> load_pending=1 until frame_done. The next frame shows all A4 (2), never F9; load_pending=0 after.
- load asserted exactly on the frame_done cycle (SYNC_LOAD=1) -> new value shown from digit 0 of the next frame; load_pending never rises.
- Assert reset during digit 2 slot -> Anode=1111 and Cathode=FF in the same cycle (async). After release, scan resumes at digit 0 with shadow=0 (digit shows C0).
